wb_stage_mi: RTL and testbench
==============================

WB_STAGE_MI -- requirements
Module: wb_stage_mi

Interface
REQ-001 Parameter LANES, default 2, number of retire lanes (legal 1..4).
REQ-002 Parameter TRACE_DEPTH, default 8, debug-trace FIFO entries (power of 2, >= LANES).
REQ-003 Parameter LANE_W, default 200, per-lane bus width; field order MSB->LSB: lvalid1, gr_we1, pc32, dest5, result32, ex1, ecode6, esubcode9, vaddr32, ertn1, csr_re1, csr_we1, csr_num14, csr_wmask32, csr_wvalue32.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_wb_valid  in  1  MEM holds a packet; mem_wb_bus  in  LANES*LANE_W  lane 0 in LSBs.
REQ-007 wb_allowin  out  1  WB accepts a packet this cycle.
REQ-008 rf_we  out  LANES; rf_waddr  out  LANES*5; rf_wdata  out  LANES*32  per-lane GPR write ports, also the ID forwarding source.
REQ-009 csr_num out 14; csr_re out 1; csr_rvalue in 32; csr_we out 1; csr_wmask out 32; csr_wvalue out 32  lane-0 CSR access.
REQ-010 wb_ex out 1; wb_csr_pc out 32; wb_ecode out 6; wb_esubcode out 9; wb_vaddr out 32; ertn_flush out 1  exception/return to CSR file.
REQ-011 debug_wb_pc out 32; debug_wb_rf_we out 4; debug_wb_rf_wnum out 5; debug_wb_rf_wdata out 32  one retirement per cycle.
REQ-012 trace_level  out  clog2(TRACE_DEPTH)+1  FIFO occupancy.

Function
REQ-013 Packet register loads mem_wb_bus when mem_wb_valid & wb_allowin; wb_valid follows mem_wb_valid on accept.
REQ-014 wb_ready_go = (TRACE_DEPTH - trace_level) >= count of lanes with lvalid & gr_we; same-cycle pop not credited.
REQ-015 wb_allowin = ~wb_valid | wb_ready_go; retire occurs when wb_valid & wb_ready_go.
REQ-016 Exception lane k = lowest-index lane with lvalid & ex; lanes < k retire normally; lanes >= k write no GPR, push no trace.
REQ-017 wb_ex = retire & any lane ex; wb_csr_pc/ecode/esubcode/vaddr taken from lane k; all zero when wb_ex=0.
REQ-018 ertn_flush = retire & lane0 lvalid & ertn & ~wb_ex; ertn/csr flags on lanes > 0 ignored.
REQ-019 On wb_ex or ertn_flush, wb_valid clears next cycle and the concurrent accept is discarded (flush beats accept).
REQ-020 Lane i rf_we = retire & lvalid & gr_we & not suppressed; rf_wdata = result, except lane 0 uses csr_rvalue when csr_re|csr_we.
REQ-021 csr_re = lane0 (csr_re|csr_we); csr_we = retire & lane0 lvalid & csr_we & ~wb_ex; csr_num/wmask/wvalue from lane 0.
REQ-022 Same dest on several lanes: all ports asserted; highest-index lane is architecturally last (RF resolves).
REQ-023 Trace FIFO pushes each writing lane in ascending lane order {pc, dest, wdata}; pops one entry per cycle when non-empty.
REQ-024 Debug outputs present FIFO head; debug_wb_rf_we = 4'hf when non-empty, else 4'h0 with pc/wnum/wdata = 0.
REQ-025 Pointers wrap modulo TRACE_DEPTH; simultaneous push and pop update trace_level by pushes-minus-1.
REQ-026 Lanes with lvalid=0 or dest=0 writes: rf_we still follows REQ-020; trace records them unchanged.

Reset
REQ-027 reset=1: wb_valid=0, FIFO pointers and trace_level=0, all strobes (rf_we, csr_we, wb_ex, ertn_flush, debug_wb_rf_we) 0 next cycle; wb_allowin=1.
REQ-028 Reset mid-operation discards the held packet and all FIFO contents; no retirement reported afterward.

Verification
REQ-029 LANES=2, both lanes gr_we, dest 3/4, results 0x11/0x22 -> rf_we=2'b11 one cycle; trace shows pc0 then pc1 on consecutive cycles.
REQ-030 Lane 1 ex ecode=0x0B, lane 0 normal -> lane 0 writes, lane 1 no write, wb_ex=1, wb_ecode=0x0B, wb_csr_pc=lane1 pc, wb_valid 0 next cycle.
REQ-031 TRACE_DEPTH=8 holding 7 entries, 2-lane write packet -> wb_allowin=0, wb_ready_go=0 until level <= 6, then retire.
REQ-032 Lane 0 csr_we with csr_rvalue=0xDEAD -> csr_we=1, rf_wdata lane 0 = 0xDEAD; with lane-0 ex set -> csr_we=0.
REQ-033 Assert reset with FIFO level 5 and packet held -> next cycle trace_level=0, debug_wb_rf_we=0, wb_allowin=1.

Source files
------------

// File: rtl/wb_stage_mi.sv
// ----------------------------------------------------------------------------
// wb_stage_mi : multi-lane write-back stage of an in-order pipeline.
//
// Holds one MEM->WB packet of LANES retire lanes, performs GPR writes, lane-0
// CSR access, exception / ertn signalling, and serialises every retired GPR
// write through a small trace FIFO so the debug port reports one retirement
// per cycle.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   mem_wb_valid, mem_wb_bus        packet from MEM (lane 0 in the LSBs)
//   wb_allowin                      WB can accept a packet this cycle
//   rf_we/rf_waddr/rf_wdata         per-lane GPR write ports (also forwarding)
//   csr_num/re/rvalue/we/wmask/wvalue   lane-0 CSR access
//   wb_ex, wb_csr_pc, wb_ecode, wb_esubcode, wb_vaddr, ertn_flush
//                                   exception / return report to CSR file
//   debug_wb_*                      head of the retirement trace FIFO
//   trace_level                     trace FIFO occupancy
// ----------------------------------------------------------------------------
module wb_stage_mi #(
    parameter int LANES       = 2,
    parameter int TRACE_DEPTH = 8,
    parameter int LANE_W      = 200,
    localparam int PTR_W      = $clog2(TRACE_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_wb_valid,
    input  logic [LANES*LANE_W-1:0] mem_wb_bus,
    output logic                    wb_allowin,
    output logic [LANES-1:0]        rf_we,
    output logic [LANES*5-1:0]      rf_waddr,
    output logic [LANES*32-1:0]     rf_wdata,
    output logic [13:0]             csr_num,
    output logic                    csr_re,
    input  logic [31:0]             csr_rvalue,
    output logic                    csr_we,
    output logic [31:0]             csr_wmask,
    output logic [31:0]             csr_wvalue,
    output logic                    wb_ex,
    output logic [31:0]             wb_csr_pc,
    output logic [5:0]              wb_ecode,
    output logic [8:0]              wb_esubcode,
    output logic [31:0]             wb_vaddr,
    output logic                    ertn_flush,
    output logic [31:0]             debug_wb_pc,
    output logic [3:0]              debug_wb_rf_we,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [31:0]             debug_wb_rf_wdata,
    output logic [LVL_W-1:0]        trace_level
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ENT_W = 32 + 5 + 32;

    // Lane field offsets (LSB position inside one lane slice)
    localparam int OFF_LVALID = 199;
    localparam int OFF_GRWE   = 198;
    localparam int OFF_PC     = 166;
    localparam int OFF_DEST   = 161;
    localparam int OFF_RES    = 129;
    localparam int OFF_EX     = 128;
    localparam int OFF_ECODE  = 122;
    localparam int OFF_ESUB   = 113;
    localparam int OFF_VADDR  = 81;
    localparam int OFF_ERTN   = 80;
    localparam int OFF_CSRRE  = 79;
    localparam int OFF_CSRWE  = 78;
    localparam int OFF_CNUM   = 64;
    localparam int OFF_WMASK  = 32;
    localparam int OFF_WVAL   = 0;

    logic                    wb_valid_reg;
    logic [LANES*LANE_W-1:0] pkt_reg;
    logic [ENT_W-1:0]        trace_mem [TRACE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [LVL_W-1:0]        level_reg;

    logic [LANES-1:0] l_valid;
    logic [LANES-1:0] l_grwe;
    logic [LANES-1:0] l_ex;
    logic [31:0]      l_pc    [LANES];
    logic [4:0]       l_dest  [LANES];
    logic [31:0]      l_res   [LANES];
    logic [5:0]       l_ecode [LANES];
    logic [8:0]       l_esub  [LANES];
    logic [31:0]      l_vaddr [LANES];
    logic [LANES-1:0] unused_lane;

    logic             ertn0;
    logic             csr_we0;
    logic             csr_re0;

    logic             exc_any;
    logic [IDX_W-1:0] exc_idx;
    logic [LANES-1:0] lane_live;
    logic [LVL_W-1:0] need_cnt;
    logic [LVL_W-1:0] free_slots;
    logic             wb_ready_go;
    logic             retire;
    logic             flush;
    logic [LVL_W-1:0] push_cnt;
    logic [PTR_W-1:0] wr_addr [LANES];
    logic             pop;
    logic [ENT_W-1:0] head;

    // ---------------------------------------------------------------- decode
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign l_valid[gi] = pkt_reg[gi*LANE_W + OFF_LVALID];
            assign l_grwe[gi]  = pkt_reg[gi*LANE_W + OFF_GRWE];
            assign l_ex[gi]    = pkt_reg[gi*LANE_W + OFF_EX];
            assign l_pc[gi]    = pkt_reg[gi*LANE_W + OFF_PC    +: 32];
            assign l_dest[gi]  = pkt_reg[gi*LANE_W + OFF_DEST  +: 5];
            assign l_res[gi]   = pkt_reg[gi*LANE_W + OFF_RES   +: 32];
            assign l_ecode[gi] = pkt_reg[gi*LANE_W + OFF_ECODE +: 6];
            assign l_esub[gi]  = pkt_reg[gi*LANE_W + OFF_ESUB  +: 9];
            assign l_vaddr[gi] = pkt_reg[gi*LANE_W + OFF_VADDR +: 32];

            // ertn/CSR fields only matter on lane 0; other lanes ignore them
            if (gi == 0) begin : g_first
                assign unused_lane[gi] = 1'b0;
            end else begin : g_rest
                assign unused_lane[gi] = ^pkt_reg[gi*LANE_W +: OFF_VADDR];
            end
        end
    endgenerate

    assign ertn0      = pkt_reg[OFF_ERTN];
    assign csr_re0    = pkt_reg[OFF_CSRRE];
    assign csr_we0    = pkt_reg[OFF_CSRWE];
    assign csr_num    = pkt_reg[OFF_CNUM  +: 14];
    assign csr_wmask  = pkt_reg[OFF_WMASK +: 32];
    assign csr_wvalue = pkt_reg[OFF_WVAL  +: 32];

    // Lowest-index excepting lane; it and every later lane are squashed.
    // The credit demand counts all valid writers, squashed or not, so the
    // stall decision does not depend on the exception search.
    always_comb begin
        exc_any   = 1'b0;
        exc_idx   = '0;
        lane_live = '0;
        need_cnt  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!exc_any && l_valid[i] && l_ex[i]) begin
                exc_any = 1'b1;
                exc_idx = IDX_W'(i);
            end
            lane_live[i] = ~exc_any;
            if (l_valid[i] && l_grwe[i]) begin
                need_cnt = need_cnt + 1'b1;
            end
        end
    end

    // A pop happening this cycle is not counted as free space
    assign free_slots  = LVL_W'(TRACE_DEPTH) - level_reg;
    assign wb_ready_go = (free_slots >= need_cnt);
    assign wb_allowin  = ~wb_valid_reg | wb_ready_go;
    assign retire      = wb_valid_reg & wb_ready_go;

    assign wb_ex      = retire & exc_any;
    assign ertn_flush = retire & l_valid[0] & ertn0 & ~wb_ex;
    assign flush      = wb_ex | ertn_flush;
    assign csr_re     = csr_re0 | csr_we0;
    assign csr_we     = retire & l_valid[0] & csr_we0 & ~wb_ex;

    always_comb begin
        wb_csr_pc   = '0;
        wb_ecode    = '0;
        wb_esubcode = '0;
        wb_vaddr    = '0;
        if (wb_ex) begin
            wb_csr_pc   = l_pc[exc_idx];
            wb_ecode    = l_ecode[exc_idx];
            wb_esubcode = l_esub[exc_idx];
            wb_vaddr    = l_vaddr[exc_idx];
        end
    end

    // ------------------------------------------------------- GPR write ports
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rf
            assign rf_we[gi]              = retire & l_valid[gi] & l_grwe[gi] & lane_live[gi];
            assign rf_waddr[gi*5 +: 5]    = l_dest[gi];
            if (gi == 0) begin : g_csr_mux
                // CSR instructions return the old CSR value to the GPR
                assign rf_wdata[31:0] = csr_re ? csr_rvalue : l_res[0];
            end else begin : g_plain
                assign rf_wdata[gi*32 +: 32] = l_res[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------ trace FIFO
    // Writing lanes are packed into consecutive slots in ascending lane order.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_addr[i] = wr_ptr_reg + push_cnt[PTR_W-1:0];
            if (rf_we[i]) begin
                push_cnt = push_cnt + 1'b1;
            end
        end
    end

    assign pop  = (level_reg != '0);
    assign head = trace_mem[rd_ptr_reg];

    assign trace_level       = level_reg;
    assign debug_wb_rf_we    = pop ? 4'hf : 4'h0;
    assign debug_wb_pc       = pop ? head[ENT_W-1 -: 32] : 32'h0;
    assign debug_wb_rf_wnum  = pop ? head[36:32] : 5'h0;
    assign debug_wb_rf_wdata = pop ? head[31:0] : 32'h0;

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
        end else begin
            // a flushing retirement kills any packet offered in the same cycle
            if (flush) begin
                wb_valid_reg <= 1'b0;
            end else if (wb_allowin) begin
                wb_valid_reg <= mem_wb_valid;
            end
            wr_ptr_reg <= wr_ptr_reg + push_cnt[PTR_W-1:0];
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            level_reg  <= level_reg + push_cnt - LVL_W'(pop);
        end
    end

    // Data path: no reset needed, validity is tracked by the control state
    always_ff @(posedge clk) begin
        if (mem_wb_valid && wb_allowin && !flush) begin
            pkt_reg <= mem_wb_bus;
        end
        for (int i = 0; i < LANES; i++) begin
            if (rf_we[i]) begin
                trace_mem[wr_addr[i]] <= {l_pc[i], l_dest[i], rf_wdata[i*32 +: 32]};
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_mi.sv
// ----------------------------------------------------------------------------
// tb_wb_stage_mi : self-checking bench for wb_stage_mi (LANES=2, depth 8).
// A queue-based behavioural model predicts every output each cycle; directed
// packets are followed by a long randomized run with occasional resets.
// ----------------------------------------------------------------------------
module tb_wb_stage_mi;

    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int LANE_W = 200;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
        logic        ertn;
        logic        cre;
        logic        cwe;
        logic [13:0] cnum;
        logic [31:0] cmask;
        logic [31:0] cval;
    } lane_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] data;
    } tr_t;

    logic                    clk;
    logic                    reset;
    logic                    mem_wb_valid;
    logic [LANES*LANE_W-1:0] mem_wb_bus;
    logic                    wb_allowin;
    logic [LANES-1:0]        rf_we;
    logic [LANES*5-1:0]      rf_waddr;
    logic [LANES*32-1:0]     rf_wdata;
    logic [13:0]             csr_num;
    logic                    csr_re;
    logic [31:0]             csr_rvalue;
    logic                    csr_we;
    logic [31:0]             csr_wmask;
    logic [31:0]             csr_wvalue;
    logic                    wb_ex;
    logic [31:0]             wb_csr_pc;
    logic [5:0]              wb_ecode;
    logic [8:0]              wb_esubcode;
    logic [31:0]             wb_vaddr;
    logic                    ertn_flush;
    logic [31:0]             debug_wb_pc;
    logic [3:0]              debug_wb_rf_we;
    logic [4:0]              debug_wb_rf_wnum;
    logic [31:0]             debug_wb_rf_wdata;
    logic [3:0]              trace_level;

    wb_stage_mi #(
        .LANES(LANES),
        .TRACE_DEPTH(DEPTH),
        .LANE_W(LANE_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_wb_valid(mem_wb_valid),
        .mem_wb_bus(mem_wb_bus),
        .wb_allowin(wb_allowin),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .csr_num(csr_num),
        .csr_re(csr_re),
        .csr_rvalue(csr_rvalue),
        .csr_we(csr_we),
        .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex),
        .wb_csr_pc(wb_csr_pc),
        .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode),
        .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush),
        .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .trace_level(trace_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit    m_known = 1'b0;
    bit    m_valid = 1'b0;
    lane_t m_pkt [LANES];
    tr_t   trace_q [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic lane_t mk_lane(input logic v, input logic we, input logic [31:0] pc,
                                      input logic [4:0] dest, input logic [31:0] res);
        lane_t l;
        l      = '0;
        l.v    = v;
        l.we   = we;
        l.pc   = pc;
        l.dest = dest;
        l.res  = res;
        return l;
    endfunction

    function automatic lane_t rand_lane();
        lane_t l;
        l.v     = ($urandom_range(0, 99) < 85);
        l.we    = ($urandom_range(0, 99) < 75);
        l.pc    = $urandom & 32'hffff_fffc;
        l.dest  = 5'($urandom);
        l.res   = $urandom;
        l.ex    = ($urandom_range(0, 99) < 10);
        l.ecode = 6'($urandom);
        l.esub  = 9'($urandom);
        l.vaddr = $urandom;
        l.ertn  = ($urandom_range(0, 99) < 8);
        l.cre   = ($urandom_range(0, 99) < 10);
        l.cwe   = ($urandom_range(0, 99) < 10);
        l.cnum  = 14'($urandom);
        l.cmask = $urandom;
        l.cval  = $urandom;
        return l;
    endfunction

    // One clock: drive inputs, check predicted outputs at the falling edge,
    // then advance the model at the rising edge.
    task automatic run_cycle(input logic rst, input logic v, input lane_t a, input lane_t b,
                             input logic [31:0] crv);
        int          need;
        int          nq;
        int          k;
        bit          ready;
        bit          allow;
        bit          ret;
        bit          exf;
        bit          ertnf;
        bit          cwe;
        logic [1:0]  exp_we;
        logic [31:0] wdata [LANES];
        tr_t         hd;
        lane_t       in_l [LANES];

        reset        = rst;
        mem_wb_valid = v;
        mem_wb_bus   = {b, a};
        csr_rvalue   = crv;
        in_l[0]      = a;
        in_l[1]      = b;

        @(negedge clk);
        need = 0;
        for (int i = 0; i < LANES; i++) if (m_pkt[i].v && m_pkt[i].we) need++;
        nq    = trace_q.size();
        ready = ((DEPTH - nq) >= need);
        allow = !m_valid || ready;
        ret   = m_valid && ready;
        k     = LANES;
        for (int i = LANES - 1; i >= 0; i--) if (m_pkt[i].v && m_pkt[i].ex) k = i;
        exf   = ret && (k < LANES);
        ertnf = ret && m_pkt[0].v && m_pkt[0].ertn && !exf;
        cwe   = ret && m_pkt[0].v && m_pkt[0].cwe && !exf;
        for (int i = 0; i < LANES; i++) begin
            exp_we[i] = ret && m_pkt[i].v && m_pkt[i].we && (i < k);
            wdata[i]  = m_pkt[i].res;
        end
        if (m_pkt[0].cre || m_pkt[0].cwe) wdata[0] = crv;

        if (m_known) begin
            check_val("wb_allowin", 64'(wb_allowin), 64'(allow));
            check_val("rf_we", 64'(rf_we), 64'(exp_we));
            for (int i = 0; i < LANES; i++) begin
                if (exp_we[i]) begin
                    check_val("rf_waddr", 64'(rf_waddr[i*5 +: 5]), 64'(m_pkt[i].dest));
                    check_val("rf_wdata", 64'(rf_wdata[i*32 +: 32]), 64'(wdata[i]));
                end
            end
            check_val("csr_we", 64'(csr_we), 64'(cwe));
            check_val("wb_ex", 64'(wb_ex), 64'(exf));
            check_val("ertn_flush", 64'(ertn_flush), 64'(ertnf));
            check_val("wb_csr_pc", 64'(wb_csr_pc), exf ? 64'(m_pkt[k].pc) : 64'h0);
            check_val("wb_ecode", 64'(wb_ecode), exf ? 64'(m_pkt[k].ecode) : 64'h0);
            check_val("wb_esubcode", 64'(wb_esubcode), exf ? 64'(m_pkt[k].esub) : 64'h0);
            check_val("wb_vaddr", 64'(wb_vaddr), exf ? 64'(m_pkt[k].vaddr) : 64'h0);
            if (m_valid) begin
                check_val("csr_re", 64'(csr_re), 64'(m_pkt[0].cre | m_pkt[0].cwe));
                check_val("csr_num", 64'(csr_num), 64'(m_pkt[0].cnum));
                check_val("csr_wmask", 64'(csr_wmask), 64'(m_pkt[0].cmask));
                check_val("csr_wvalue", 64'(csr_wvalue), 64'(m_pkt[0].cval));
            end
            check_val("trace_level", 64'(trace_level), 64'(nq));
            hd = (nq > 0) ? trace_q[0] : '0;
            check_val("dbg_rf_we", 64'(debug_wb_rf_we), (nq > 0) ? 64'hf : 64'h0);
            check_val("dbg_pc", 64'(debug_wb_pc), 64'(hd.pc));
            check_val("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(hd.dest));
            check_val("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(hd.data));
        end

        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_known = 1'b1;
            trace_q.delete();
        end else begin
            if (ret) begin
                $display("retire t=%0t we=%b ex=%0d ertn=%0d level=%0d",
                         $time, exp_we, exf, ertnf, nq);
            end
            if (nq > 0) void'(trace_q.pop_front());
            for (int i = 0; i < LANES; i++) begin
                if (exp_we[i]) trace_q.push_back('{pc: m_pkt[i].pc, dest: m_pkt[i].dest, data: wdata[i]});
            end
            if (exf || ertnf) begin
                m_valid = 1'b0;
            end else if (allow) begin
                m_valid = v;
                if (v) begin
                    m_pkt[0] = in_l[0];
                    m_pkt[1] = in_l[1];
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, '0, $urandom);
    endtask

    lane_t la;
    lane_t lb;

    initial begin
        reset        = 1'b1;
        mem_wb_valid = 1'b0;
        mem_wb_bus   = '0;
        csr_rvalue   = '0;
        m_pkt[0]     = '0;
        m_pkt[1]     = '0;
        @(posedge clk);
        #1;

        // reset, then two-lane GPR write traced in lane order
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, '0, '0, 32'h0);
        run_cycle(1'b0, 1'b1, mk_lane(1, 1, 32'h1000, 5'd3, 32'h11),
                  mk_lane(1, 1, 32'h1004, 5'd4, 32'h22), 32'h0);
        idle(4);

        // lane 1 exception; the packet offered during the flush must be dropped
        lb       = mk_lane(1, 1, 32'h2004, 5'd7, 32'h77);
        lb.ex    = 1'b1;
        lb.ecode = 6'h0b;
        run_cycle(1'b0, 1'b1, mk_lane(1, 1, 32'h2000, 5'd6, 32'h66), lb, 32'h0);
        run_cycle(1'b0, 1'b1, mk_lane(1, 1, 32'h3000, 5'd8, 32'h88),
                  mk_lane(1, 1, 32'h3004, 5'd9, 32'h99), 32'h0);
        idle(4);

        // lane-0 CSR write returns csr_rvalue, then the same with an exception
        la     = mk_lane(1, 1, 32'h4000, 5'd10, 32'h1234);
        la.cwe = 1'b1;
        la.cnum = 14'h6;
        run_cycle(1'b0, 1'b1, la, mk_lane(0, 0, 32'h0, 5'd0, 32'h0), 32'hdead);
        run_cycle(1'b0, 1'b0, '0, '0, 32'hdead);
        la.ex = 1'b1;
        run_cycle(1'b0, 1'b1, la, mk_lane(0, 0, 32'h0, 5'd0, 32'h0), 32'hdead);
        idle(4);

        // fill the trace FIFO until back-pressure, then drain
        for (int n = 0; n < 10; n++) begin
            run_cycle(1'b0, 1'b1, mk_lane(1, 1, 32'h5000 + 8*n, 5'd11, 32'(n)),
                      mk_lane(1, 1, 32'h5004 + 8*n, 5'd12, ~32'(n)), $urandom);
        end
        idle(12);

        // reset with FIFO partly full and a packet held
        for (int n = 0; n < 5; n++) begin
            run_cycle(1'b0, 1'b1, mk_lane(1, 1, 32'h6000 + 8*n, 5'd13, 32'(n)),
                      mk_lane(1, 1, 32'h6004 + 8*n, 5'd14, 32'(n)), $urandom);
        end
        run_cycle(1'b1, 1'b1, mk_lane(1, 1, 32'h7000, 5'd1, 32'h1),
                  mk_lane(1, 1, 32'h7004, 5'd2, 32'h2), 32'h0);
        idle(3);

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            run_cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
                      rand_lane(), rand_lane(), $urandom);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
